// File: rtl/mem_dump_unit.sv
// mem_dump_unit: streams a block of words from a data memory to a ready/valid sink.
// Define MEM_DUMP_CHECKSUM_EN to append a modulo-2^DATA_WIDTH sum word to each dump.
module mem_dump_unit #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] checksum
);
`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, DONE} state_t;
`endif
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  accept, final_word;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif
  assign accept     = state_q == SEND && out_ready;
  assign final_word = cnt_q == ONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = accept ? addr_q + 1'b1 : addr_q;
    cnt_d   = accept ? cnt_q - 1'b1 : cnt_q;
    data_d  = state_q == CAPTURE ? mem_rdata : data_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    csum_d  = accept ? csum_q + data_q : csum_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        addr_d  = base_addr;
        cnt_d   = word_count;
`ifdef MEM_DUMP_CHECKSUM_EN
        csum_d  = '0;
`endif
        state_d = word_count == '0 ? DONE : READ;
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = SEND;
`ifdef MEM_DUMP_CHECKSUM_EN
      SEND:    state_d = !out_ready ? SEND : final_word ? CSUM : READ;
      CSUM:    state_d = out_ready ? DONE : CSUM;
`else
      SEND:    state_d = !out_ready ? SEND : final_word ? DONE : READ;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign mem_re   = state_q == READ;
  assign mem_addr = addr_q;
`ifdef MEM_DUMP_CHECKSUM_EN
  // The checksum word travels on the same stream, after the last data word.
  assign out_valid = state_q == SEND || state_q == CSUM;
  assign out_data  = state_q == CSUM ? csum_q : data_q;
  assign out_last  = state_q == CSUM;
  assign checksum  = csum_q;
`else
  assign out_valid = state_q == SEND;
  assign out_data  = data_q;
  assign out_last  = state_q == SEND && final_word;
  assign checksum  = '0;
`endif
endmodule

// File: tb/tb_mem_dump_unit.sv
// tb_mem_dump_unit: table-driven and randomized checks of mem_dump_unit against a queue-based model.
module tb_mem_dump_unit;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic        clk = 0, reset = 1, start = 0, out_ready = 1;
  logic [12:0] base_addr = '0, mem_addr;
  logic [13:0] word_count = '0;
  logic        busy, done, mem_re, out_valid, out_last;
  logic [31:0] mem_rdata, out_data, checksum;
  logic [31:0] mem [8192];
  logic [31:0] got[$];
  logic        lst[$];
  int          n_chk = 0, n_err = 0;

  mem_dump_unit dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic dump(input logic [12:0] b, input logic [13:0] c, input int stall_at,
                      input int stall_len, input bit rnd, input bit poke);
    logic [31:0] exp[$];
    logic [12:0] ea[$];
    logic [12:0] addrs[$];
    logic [31:0] sum = 0;
    int t = 1, acc = 0, stall = 0, fv = -1, la = -1, dt = -1, bad = 0;
    got.delete();
    lst.delete();
    for (int i = 0; i < int'(c); i++) begin
      logic [12:0] a = b + 13'(i);
      ea.push_back(a);
      exp.push_back(mem[a]);
      sum += mem[a];
    end
    if (CS == 1 && c != 0) exp.push_back(sum);
    @(negedge clk);
    start = 1; base_addr = b; word_count = c; out_ready = 1;
    @(negedge clk);
    start = 0;
    while (dt < 0 && t < 300) begin
      start = poke && t == 2;
      base_addr = ~b;
      if (out_valid && acc == stall_at && stall < stall_len) begin
        out_ready = 0;
        stall++;
      end else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_re) addrs.push_back(mem_addr);
      if (out_valid) begin
        if (fv < 0) fv = t;
        if (acc >= exp.size()) bad++;
        else if (out_data !== exp[acc] || out_last !== (acc == exp.size() - 1)) bad++;
        if (out_ready) begin
          got.push_back(out_data);
          lst.push_back(out_last);
          acc++;
          la = t;
        end
      end
      if (done) dt = t;
      else begin
        @(negedge clk);
        t++;
      end
    end
    chk("done_seen", 64'(dt >= 0), 1);
    if (dt >= 0) begin
      chk("checksum", checksum, CS == 1 ? sum : 0);
      start = poke;
      @(negedge clk);
      start = 0;
      chk("done_one_cycle_start_ignored", {done, busy}, 0);
    end
    chk("n_words", got.size(), exp.size());
    chk("stream_bad_cycles", bad, 0);
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      chk($sformatf("word%0d", i), got[i], exp[i]);
      chk($sformatf("last%0d", i), lst[i], i == exp.size() - 1);
    end
    chk("n_reads", addrs.size(), ea.size());
    for (int i = 0; i < addrs.size() && i < ea.size(); i++)
      chk($sformatf("addr%0d", i), addrs[i], ea[i]);
    if (c != 0) begin
      chk("first_valid_edge", fv, 3);
      chk("done_after_accept", dt, la + 1);
    end else begin
      chk("zero_done_edge", dt, 1);
      chk("zero_no_valid", fv, -1);
    end
    out_ready = 1;
  endtask

  typedef struct packed {
    logic [12:0] base;
    logic [13:0] cnt;
    logic [7:0]  stall_at;
    logic [7:0]  stall_len;
    logic [31:0] first;
    logic [31:0] lastd;
    logic [31:0] sum;
  } vec_t;

  vec_t vt[5];

  initial begin
    int k;
    for (int i = 0; i < 8192; i++) mem[i] = $urandom;
    mem[2048] = 1; mem[2049] = 2; mem[2050] = 3; mem[2051] = 5;
    mem[8190] = 32'hA; mem[8191] = 32'hB; mem[0] = 32'hC;
    vt[0] = '{13'd2048, 14'd4, 8'hFF, 8'd0, 32'd1, 32'd5, 32'd11};
    vt[1] = '{13'd2048, 14'd4, 8'd1,  8'd5, 32'd1, 32'd5, 32'd11};
    vt[2] = '{13'd8190, 14'd3, 8'hFF, 8'd0, 32'hA, 32'hC, 32'h21};
    vt[3] = '{13'd2049, 14'd1, 8'hFF, 8'd0, 32'd2, 32'd2, 32'd2};
    vt[4] = '{13'd2048, 14'd0, 8'hFF, 8'd0, 32'd0, 32'd0, 32'd0};
    repeat (2) @(negedge clk);
    chk("reset_flags", {busy, done, mem_re, out_valid, out_last}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_data", out_data, 0);
    chk("reset_csum", checksum, 0);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      dump(vt[i].base, vt[i].cnt, int'(vt[i].stall_at), int'(vt[i].stall_len), 0, i == 4);
      chk($sformatf("vec%0d_count", i), got.size(), vt[i].cnt == 0 ? 0 : int'(vt[i].cnt) + CS);
      if (got.size() > 0) begin
        chk($sformatf("vec%0d_first", i), got[0], vt[i].first);
        chk($sformatf("vec%0d_final", i), got[got.size() - 1], CS == 1 ? vt[i].sum : vt[i].lastd);
      end
    end
    // Reset while the second of four words is waiting at the sink.
    @(negedge clk);
    start = 1; base_addr = 13'd2048; word_count = 14'd4; out_ready = 1;
    @(negedge clk);
    start = 0;
    k = 0;
    for (int t = 0; t < 50 && !(out_valid && k == 1); t++) begin
      if (out_valid && out_ready) k++;
      @(negedge clk);
    end
    chk("rst_word2_reached", {out_valid, out_data}, {1'b1, 32'd2});
    reset = 1;
    @(negedge clk);
    chk("rst_mid_flags", {busy, done, mem_re, out_valid, out_last}, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_csum", checksum, 0);
    reset = 0;
    k = 0;
    repeat (6) begin
      @(negedge clk);
      k += int'(done) + int'(busy);
    end
    chk("rst_no_done", k, 0);
    dump(13'd8190, 14'd3, -1, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      dump(13'($urandom), 14'($urandom_range(0, 6)), -1, 0, 1, i[0]);
    dump(13'd8189, 14'd5, 2, 3, 1, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
